// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_pkg
// Description : Shared encodings for the next-PC sequencer.
//               Covers PC-select codes, sequencer states and trap cause codes.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

  // PC select encodings presented to the program counter
  localparam logic [1:0] PS_HOLD  = 2'b00;
  localparam logic [1:0] PS_INC   = 2'b01;
  localparam logic [1:0] PS_REDIR = 2'b10;
  localparam logic [1:0] PS_VEC   = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Trap cause codes
  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_EXT  = 2'b01;
  localparam logic [1:0] CAUSE_MIS  = 2'b10;

endpackage : pc_sequencer_pkg
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Next-PC controller. Chooses hold / PC+4 / redirect / vector
//               each cycle. Owns the boot sequence, the post-redirect flush
//               bubble, the exception PC and the double-fault halt.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
  parameter logic [63:0] TRAP_VECTOR  = 64'h0000_0000_0000_0100,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc_out,
  input  logic [63:0] pc4,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        jump,
  input  logic [63:0] jump_target,
  input  logic        trap_req,
  input  logic        mret,
  output logic [63:0] pc_in,
  output logic [1:0]  ps,
  output logic        flush,
  output logic        fetch_valid,
  output logic [63:0] epc,
  output logic [1:0]  cause,
  output logic        halted
);

  // Counter value loaded on FLUSH entry; FLUSH lasts FLUSH_CYCLES cycles
  localparam logic [1:0] c_flush_init = 2'(FLUSH_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_flush_cnt, w_flush_cnt_nxt;
  logic [63:0] r_epc, w_epc_nxt;
  logic [1:0]  r_cause, w_cause_nxt;
  logic        r_in_trap, w_in_trap_nxt;
  logic        w_misaligned;
  logic        w_take_trap;

  assign epc   = r_epc;
  assign cause = r_cause;

  // A misaligned target only matters for the redirect that would win (jump over branch)
  assign w_misaligned = jump ? (jump_target[1:0] != 2'b00)
                             : (branch_taken && (branch_target[1:0] != 2'b00));

  // Traps are taken from RUN (external or misaligned) and from FLUSH (external only)
  assign w_take_trap = ((r_state == ST_RUN) && (trap_req || w_misaligned)) ||
                       ((r_state == ST_FLUSH) && trap_req);

  // State and architectural registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_BOOT;
      r_flush_cnt <= 2'd0;
      r_epc       <= 64'd0;
      r_cause     <= CAUSE_NONE;
      r_in_trap   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_epc       <= w_epc_nxt;
      r_cause     <= w_cause_nxt;
      r_in_trap   <= w_in_trap_nxt;
    end
  end

  // Next-state decode and PC-select outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    w_epc_nxt       = r_epc;
    w_cause_nxt     = r_cause;
    w_in_trap_nxt   = r_in_trap;
    ps              = PS_HOLD;
    pc_in           = pc4;
    flush           = 1'b0;
    fetch_valid     = 1'b0;
    halted          = 1'b0;

    if (w_take_trap) begin
      flush = 1'b1;
      if (r_in_trap) begin
        // Fault inside the handler: stop for good
        w_state_nxt = ST_HALT;
        ps          = PS_HOLD;
      end else begin
        ps              = PS_VEC;
        pc_in           = TRAP_VECTOR;
        w_epc_nxt       = pc_out;
        w_cause_nxt     = trap_req ? CAUSE_EXT : CAUSE_MIS;
        w_in_trap_nxt   = 1'b1;
        w_state_nxt     = ST_FLUSH;
        w_flush_cnt_nxt = c_flush_init;
      end
    end else begin
      case (r_state)
        ST_BOOT: begin
          ps          = PS_VEC;
          pc_in       = RESET_VECTOR;
          flush       = 1'b1;
          w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (mret) begin
            ps              = PS_REDIR;
            pc_in           = r_epc;
            flush           = 1'b1;
            w_in_trap_nxt   = 1'b0;
            w_cause_nxt     = CAUSE_NONE;
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = c_flush_init;
          end else if (jump || branch_taken) begin
            ps              = PS_REDIR;
            pc_in           = jump ? jump_target : branch_target;
            flush           = 1'b1;
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = c_flush_init;
          end else if (stall) begin
            ps          = PS_HOLD;
            fetch_valid = 1'b1;
          end else begin
            ps          = PS_INC;
            pc_in       = pc4;
            fetch_valid = 1'b1;
          end
        end
        ST_FLUSH: begin
          // Redirects seen here come from killed instructions and are dropped
          flush = 1'b1;
          if (r_flush_cnt == 2'd0) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 2'd1;
          end
        end
        default: begin
          flush  = 1'b1;
          halted = 1'b1;
        end
      endcase
    end

    // Reset presents the boot request regardless of the current state
    if (reset) begin
      ps          = PS_VEC;
      pc_in       = RESET_VECTOR;
      flush       = 1'b1;
      fetch_valid = 1'b0;
      halted      = 1'b0;
    end
  end

endmodule : pc_sequencer
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller that drives the select and load-value inputs of the program counter. It decides each cycle whether the PC holds, advances to PC+4, loads a branch/jump target, or loads a trap or return vector. It sits between the execute/branch logic, the exception source and the program counter. It also owns the boot sequence, the redirect flush bubble, the exception PC and the double-fault halt.

## Interface
- RESET_VECTOR, 64'h0000_0000_0000_0000, address loaded on boot
- TRAP_VECTOR, 64'h0000_0000_0000_0100, handler entry address
- FLUSH_CYCLES, 2, bubble cycles after any redirect (1..3)

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pc_out  in  64  current PC from program counter
- pc4  in  64  pc_out+4 from program counter
- stall  in  1  pipeline stall, hold PC
- branch_taken  in  1  resolved taken branch this cycle
- branch_target  in  64  branch destination
- jump  in  1  unconditional jump this cycle
- jump_target  in  64  jump destination
- trap_req  in  1  external exception request
- mret  in  1  return from handler
- pc_in  out  64  load value to program counter
- ps  out  2  PC select: 00 hold, 01 PC+4, 10 load pc_in (redirect), 11 load pc_in (vector)
- flush  out  1  kill fetched/decoded instructions
- fetch_valid  out  1  current PC fetch is architecturally valid
- epc  out  64  saved exception PC
- cause  out  2  00 none, 01 external, 10 misaligned target
- halted  out  1  double-fault halt indicator

## Operation
- States: BOOT, RUN, FLUSH, HALT. Register in_trap, down-counter flush_cnt (2 bits).
- The state register, epc, cause and in_trap are registered. ps, pc_in, flush and fetch_valid are combinational from state and inputs.
- BOOT: ps=11, pc_in=RESET_VECTOR, flush=1, fetch_valid=0. Goes to RUN next cycle.
- RUN event priority: trap > mret > jump > branch > stall > sequential.
  - Trap condition: trap_req=1, or jump/branch with target[1:0]!=0.
  - Trap with in_trap=0: ps=11, pc_in=TRAP_VECTOR, flush=1. epc<=pc_out, cause<=01 (external) or 10 (misaligned), in_trap<=1. Go to FLUSH.
  - Trap with in_trap=1: go to HALT, ps=00.
  - mret: ps=10, pc_in=epc, flush=1, in_trap<=0, cause<=00. Go to FLUSH.
  - jump: ps=10, pc_in=jump_target, flush=1. Go to FLUSH. Branch is handled the same way using branch_target.
  - stall: ps=00, fetch_valid=1.
  - Otherwise: ps=01, pc_in=pc4, fetch_valid=1.
- FLUSH: flush_cnt loads FLUSH_CYCLES-1 on entry. In this state ps=00, flush=1, fetch_valid=0. The counter decrements each cycle, and the state returns to RUN when the counter is 0.
  - trap_req in FLUSH is accepted exactly as in RUN.
  - jump, branch and mret in FLUSH are ignored; they belong to killed instructions.
- HALT: ps=00, flush=1, fetch_valid=0, halted=1. Only reset exits HALT.
- Widths: all addresses are 64-bit. There is no arithmetic here; pc4 is supplied by the PC.

## Timing
- Reset, cycle 0: state<=BOOT, epc<=0, cause<=00, in_trap<=0, flush_cnt<=0. halted=0.
- While reset is high, outputs equal BOOT outputs: ps=11, pc_in=RESET_VECTOR, flush=1, fetch_valid=0.
- A reset asserted mid-FLUSH or in HALT takes effect on the next edge and aborts everything.
- Redirect latency: the select is presented in cycle N, and the PC holds the new value after edge N.
- The first valid fetch of the new path is at cycle N+1+FLUSH_CYCLES.
- A stall together with a redirect: the redirect wins, because stall has lowest priority.
- trap_req and mret in the same cycle: the trap wins. epc captures pc_out and in_trap stays 1; if in_trap was already 1, the block goes to HALT.
- Sequential wrap-around: pc4 wraps at 2^64 and is passed through unchanged.

## Structure
- Shared package holds:
  - ps encodings: PS_HOLD, PS_INC, PS_REDIR, PS_VEC.
  - State enum.
  - Cause codes.
- No sub-module. The flush counter stays inline.

## Test plan
- Reset high 2 cycles, then low -> ps=11 and pc_in=0 during reset and BOOT, then ps=01 with fetch_valid=1 from the cycle after BOOT.
- In RUN with pc_out=0x40, branch_taken=1, branch_target=0x200 -> ps=10, pc_in=0x200, flush=1; with FLUSH_CYCLES=2, flush stays high and fetch_valid low for 2 cycles, then RUN.
- trap_req at pc_out=0x88 -> ps=11, pc_in=0x100, epc=0x88, cause=01. A later mret gives ps=10, pc_in=0x88, cause=00.
- jump_target=0x202 (misaligned) -> trap taken, cause=10, epc=current pc_out, and no load of 0x202.
- A second trap_req while in_trap=1 -> halted=1, ps=00, and the block stays halted until reset. After reset, halted=0 and BOOT outputs return.
- stall held 3 cycles in RUN -> ps=00 each cycle; then branch_taken arrives together with stall=1 -> the redirect is taken.
